// File: rtl/regincr_pipe.sv
// regincr_pipe: NSTAGES-deep valid/ready pipeline; each stage adds INC to the
// message as it enters. Bubbles collapse: an empty stage always accepts from
// upstream, even while downstream stages stall.
// Optional build macro: REGINCR_PIPE_SAT_EN -- saturate each stage add at
// 2^WIDTH-1 instead of wrapping modulo 2^WIDTH.
module regincr_pipe #(
    parameter int WIDTH   = 8,
    parameter int NSTAGES = 2,
    parameter int INC     = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_val,
    output logic                           in_rdy,
    input  logic [WIDTH-1:0]               in_msg,
    output logic                           out_val,
    input  logic                           out_rdy,
    output logic [WIDTH-1:0]               out_msg,
    output logic [$clog2(NSTAGES+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(NSTAGES + 1);

    logic [NSTAGES-1:0] valid_q;
    logic [NSTAGES-1:0] valid_d;
    logic [NSTAGES-1:0] adv;
    logic [NSTAGES-1:0] up_val;
    logic [WIDTH-1:0]   data_q  [NSTAGES];
    logic [WIDTH-1:0]   data_d  [NSTAGES];
    logic [WIDTH-1:0]   up_data [NSTAGES];

    // One stage's add; the carry out of the extended sum marks overflow.
    function automatic logic [WIDTH-1:0] stage_add(input logic [WIDTH-1:0] a);
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + (WIDTH+1)'(INC);
`ifdef REGINCR_PIPE_SAT_EN
        return sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        return sum[WIDTH-1:0];
`endif
    endfunction

    // Stage k may load when the output is being taken or some stage at or
    // after k is empty (a hole downstream lets everything upstream of it move).
    // Upstream of stage 0 is the input port; upstream of stage k is stage k-1.
    genvar gi;
    generate
        for (gi = 0; gi < NSTAGES; gi++) begin : g_stage
            assign adv[gi] = out_rdy || !(&valid_q[NSTAGES-1:gi]);
            if (gi == 0) begin : g_first
                assign up_val[gi]  = in_val;
                assign up_data[gi] = in_msg;
            end else begin : g_rest
                assign up_val[gi]  = valid_q[gi-1];
                assign up_data[gi] = data_q[gi-1];
            end
        end
    endgenerate

    // Next-state: an advancing stage takes its upstream valid; data only
    // changes when a real message moves in, so idle data never shifts.
    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < NSTAGES; k++) begin
            data_d[k] = data_q[k];
            if (adv[k]) begin
                valid_d[k] = up_val[k];
                if (up_val[k]) begin
                    data_d[k] = stage_add(up_data[k]);
                end
            end
        end
    end

    // Stage registers; reset clears everything and wins over any transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 0; k < NSTAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < NSTAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Occupancy is the population count of the stage valid bits.
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < NSTAGES; k++) begin
            occupancy = occupancy + OCC_W'(valid_q[k]);
        end
    end

    assign in_rdy  = adv[0];
    assign out_val = valid_q[NSTAGES-1];
    assign out_msg = data_q[NSTAGES-1];

endmodule

// File: tb/tb_regincr_pipe.sv
// tb_regincr_pipe: directed bench for regincr_pipe with a scoreboard.
// Instance a uses defaults (8/2/1), instance b uses WIDTH=16, NSTAGES=4, INC=3.
// Expected values honour REGINCR_PIPE_SAT_EN when the bench is built with it.
module tb_regincr_pipe;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_in_val, a_in_rdy, a_out_val, a_out_rdy;
    logic [7:0]  a_in_msg, a_out_msg;
    logic [1:0]  a_occ;
    logic        b_in_val, b_in_rdy, b_out_val, b_out_rdy;
    logic [15:0] b_in_msg, b_out_msg;
    logic [2:0]  b_occ;

    sb_entry_t qa[$];
    sb_entry_t qb[$];
    int n_checks  = 0;
    int n_pass    = 0;
    int cyc       = 0;
    int spurious  = 0;
    bit lat_on    = 1'b1;

    regincr_pipe #(.WIDTH(8), .NSTAGES(2), .INC(1)) dut_a (
        .clk(clk), .reset(reset),
        .in_val(a_in_val), .in_rdy(a_in_rdy), .in_msg(a_in_msg),
        .out_val(a_out_val), .out_rdy(a_out_rdy), .out_msg(a_out_msg),
        .occupancy(a_occ)
    );

    regincr_pipe #(.WIDTH(16), .NSTAGES(4), .INC(3)) dut_b (
        .clk(clk), .reset(reset),
        .in_val(b_in_val), .in_rdy(b_in_rdy), .in_msg(b_in_msg),
        .out_val(b_out_val), .out_rdy(b_out_rdy), .out_msg(b_out_msg),
        .occupancy(b_occ)
    );

    always #5 clk = ~clk;

    // Reference: apply n per-stage adds of inc at width w, wrapping or saturating.
    function automatic logic [31:0] model(int w, int n, int inc, logic [31:0] x);
        longint v;
        longint lim;
        lim = longint'(1) << w;
        v = longint'(x);
        for (int s = 0; s < n; s++) begin
            v = v + inc;
`ifdef REGINCR_PIPE_SAT_EN
            if (v >= lim) v = lim - 1;
`else
            v = v % lim;
`endif
        end
        return v[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock: observe at the falling edge (pop outputs, push accepted
    // inputs), then let the rising edge happen and return 1ns after it.
    task automatic tick();
        sb_entry_t e;
        @(negedge clk);
        if (!reset) begin
            if (a_out_val && a_out_rdy) begin
                if (qa.size() == 0) begin
                    spurious++;
                end else begin
                    e = qa.pop_front();
                    check("a_out_msg", 32'(a_out_msg), e.val);
                    if (lat_on) check("a_latency", 32'(cyc - e.cyc), 32'd2);
                    $display("a out 0x%02h (cycle %0d)", a_out_msg, cyc);
                end
            end
            if (a_in_val && a_in_rdy) begin
                qa.push_back('{model(8, 2, 1, 32'(a_in_msg)), cyc});
                $display("a in  0x%02h (cycle %0d)", a_in_msg, cyc);
            end
            if (b_out_val && b_out_rdy) begin
                if (qb.size() == 0) begin
                    spurious++;
                end else begin
                    e = qb.pop_front();
                    check("b_out_msg", 32'(b_out_msg), e.val);
                    check("b_latency", 32'(cyc - e.cyc), 32'd4);
                    $display("b out 0x%04h (cycle %0d)", b_out_msg, cyc);
                end
            end
            if (b_in_val && b_in_rdy) begin
                qb.push_back('{model(16, 4, 3, 32'(b_in_msg)), cyc});
                $display("b in  0x%04h (cycle %0d)", b_in_msg, cyc);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send_a(input logic [7:0] m);
        a_in_val = 1'b1;
        a_in_msg = m;
        tick();
        a_in_val = 1'b0;
    endtask

    // Run with out_rdy high until both scoreboards empty, within a bound.
    task automatic drain(input int max_cycles);
        a_out_rdy = 1'b1;
        b_out_rdy = 1'b1;
        for (int i = 0; i < max_cycles && (qa.size() != 0 || qb.size() != 0); i++) begin
            tick();
        end
        if (qa.size() != 0 || qb.size() != 0)
            check("drain_timeout", 32'(qa.size() + qb.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        a_in_val = 1'b0; a_in_msg = 8'h00; a_out_rdy = 1'b1;
        b_in_val = 1'b0; b_in_msg = 16'h0000; b_out_rdy = 1'b1;

        // Reset state
        tick();
        reset = 1'b0;
        check("reset_out_val", 32'(a_out_val), 32'd0);
        check("reset_out_msg", 32'(a_out_msg), 32'd0);
        check("reset_occupancy", 32'(a_occ), 32'd0);
        check("reset_in_rdy", 32'(a_in_rdy), 32'd1);

        // Latency: single message, then three back-to-back
        send_a(8'h05);
        drain(10);
        a_in_val = 1'b1;
        a_in_msg = 8'h10; tick();
        a_in_msg = 8'h11; tick();
        check("full_occupancy", 32'(a_occ), 32'd2);
        check("full_in_rdy_streaming", 32'(a_in_rdy), 32'd1);
        a_in_msg = 8'h12; tick();
        a_in_val = 1'b0;
        drain(10);

        // Wrap / saturate boundary
        send_a(8'hFF);
        send_a(8'hFE);
        send_a(8'h00);
        drain(10);

        // Backpressure
        lat_on = 1'b0;
        a_out_rdy = 1'b0;
        send_a(8'h01);
        send_a(8'h02);
        a_in_val = 1'b1;
        a_in_msg = 8'h03;
        tick();
        check("bp_occupancy", 32'(a_occ), 32'd2);
        check("bp_in_rdy", 32'(a_in_rdy), 32'd0);
        check("bp_out_val", 32'(a_out_val), 32'd1);
        check("bp_out_msg", 32'(a_out_msg), 32'h03);
        tick();
        check("bp_out_msg_stable", 32'(a_out_msg), 32'h03);
        check("bp_qa_two_accepted", 32'(qa.size()), 32'd2);
        a_out_rdy = 1'b1;
        for (int i = 0; i < 10 && qa.size() < 3 && a_in_val; i++) begin
            if (a_in_rdy) begin
                tick();
                a_in_val = 1'b0;
            end else begin
                tick();
            end
        end
        a_in_val = 1'b0;
        drain(10);

        // Reset mid-operation
        a_out_rdy = 1'b0;
        send_a(8'h40);
        send_a(8'h41);
        check("mid_occupancy_before", 32'(a_occ), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        qa.delete();
        check("mid_occupancy", 32'(a_occ), 32'd0);
        check("mid_out_val", 32'(a_out_val), 32'd0);
        check("mid_in_rdy", 32'(a_in_rdy), 32'd1);
        a_out_rdy = 1'b1;
        repeat (6) tick();
        check("mid_no_stale", 32'(spurious), 32'd0);

        // Random traffic with random backpressure
        for (int i = 0; i < 40; i++) begin
            a_in_val  = 1'($urandom_range(0, 1));
            a_in_msg  = 8'($urandom);
            a_out_rdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        a_in_val = 1'b0;
        drain(20);
        lat_on = 1'b1;

        // Parametrised instance: 0x0100 through four +3 stages
        b_in_val = 1'b1;
        b_in_msg = 16'h0100;
        tick();
        b_in_val = 1'b0;
        check("b_expected_value", qb.size() > 0 ? qb[0].val : 32'hFFFF_FFFF, 32'h010C);
        drain(10);
        b_in_val = 1'b1;
        b_in_msg = 16'hFFFE;
        tick();
        b_in_val = 1'b0;
        drain(10);

        check("no_spurious_outputs", 32'(spurious), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
